// File: rtl/lcd_refresh_scheduler.sv
// Frame sequencer for a 16x2 character LCD: boot init, then redraws on line-buffer change or refresh.
// Optional LCD_LINE_SKIP_EN: update frames redraw only the line(s) that changed.
module lcd_refresh_scheduler #(
  parameter int DLY_CYCLES = 262142
) (
  input  logic         iCLK,
  input  logic         rst,
  input  logic [143:0] iLine1,
  input  logic [143:0] iLine2,
  input  logic         iRefresh,
  output logic [7:0]   oByte,
  output logic         oRS,
  output logic         oStart,
  input  logic         iDone,
  output logic         oBusy,
  output logic         oFrameDone
);

  typedef enum logic [2:0] {BOOT, IDLE, ISSUE, ARM, WAIT, GAP, ADV} state_t;

  localparam logic [17:0] GAP_LAST  = (DLY_CYCLES <= 1) ? 18'd0 : 18'(DLY_CYCLES - 1);
  localparam logic [5:0]  IDX_L1    = 6'd4;
  localparam logic [5:0]  IDX_L1END = 6'd20;
  localparam logic [5:0]  IDX_L2    = 6'd21;
  localparam logic [5:0]  IDX_END   = 6'd37;

  state_t        state_q, state_d;
  logic [5:0]    idx_q, idx_d, last_q, last_d;
  logic [143:0]  sh1_q, sh1_d, sh2_q, sh2_d;
  logic          pend_q, pend_d;
  logic [17:0]   gap_q, gap_d;
  logic [7:0]    byte_q, byte_d;
  logic          rs_q, rs_d, start_q, start_d, busy_q, busy_d, fdone_q, fdone_d;

  logic [8:0]    l1 [16];
  logic [8:0]    l2 [16];
  logic [8:0]    entry;
  logic          d1, d2, refresh, trig;

  for (genvar g = 0; g < 16; g++) begin : g_unpack
    assign l1[g] = sh1_q[143-9*g -: 9];
    assign l2[g] = sh2_q[143-9*g -: 9];
  end

  always_comb begin
    entry = 9'h000;
    if (idx_q <= IDX_L1) begin
      case (idx_q)
        6'd0:    entry = 9'h038;
        6'd1:    entry = 9'h00C;
        6'd2:    entry = 9'h001;
        6'd3:    entry = 9'h006;
        default: entry = 9'h080;
      endcase
    end else if (idx_q <= IDX_L1END) begin
      entry = l1[4'(idx_q - 6'd5)];
    end else if (idx_q == IDX_L2) begin
      entry = 9'h0C0;
    end else begin
      entry = l2[4'(idx_q - 6'd22)];
    end
  end

  assign d1      = (iLine1 != sh1_q);
  assign d2      = (iLine2 != sh2_q);
  assign refresh = pend_q | iRefresh;
  assign trig    = d1 | d2 | refresh;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    sh1_d   = sh1_q;
    sh2_d   = sh2_q;
    pend_d  = pend_q | iRefresh;
    gap_d   = gap_q;
    byte_d  = byte_q;
    rs_d    = rs_q;
    start_d = start_q;
    fdone_d = 1'b0;
    case (state_q)
      BOOT: begin
        sh1_d   = iLine1;
        sh2_d   = iLine2;
        idx_d   = 6'd0;
        last_d  = IDX_END;
        pend_d  = 1'b0;
        state_d = ISSUE;
      end
      IDLE: begin
        if (trig) begin
          pend_d  = 1'b0;
          state_d = ISSUE;
`ifdef LCD_LINE_SKIP_EN
          if (refresh || (d1 && d2)) begin
            idx_d  = IDX_L1;
            last_d = IDX_END;
            sh1_d  = iLine1;
            sh2_d  = iLine2;
          end else if (d1) begin
            idx_d  = IDX_L1;
            last_d = IDX_L1END;
            sh1_d  = iLine1;
          end else begin
            idx_d  = IDX_L2;
            last_d = IDX_END;
            sh2_d  = iLine2;
          end
`else
          idx_d  = IDX_L1;
          last_d = IDX_END;
          sh1_d  = iLine1;
          sh2_d  = iLine2;
`endif
        end
      end
      ISSUE: begin
        byte_d  = entry[7:0];
        rs_d    = entry[8];
        start_d = 1'b1;
        state_d = ARM;
      end
      // iDone may still be high from the previous byte; wait for the writer to take this one
      ARM: if (!iDone) state_d = WAIT;
      WAIT: begin
        if (iDone) begin
          start_d = 1'b0;
          gap_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_q >= GAP_LAST) state_d = ADV;
        else                   gap_d   = gap_q + 18'd1;
      end
      ADV: begin
        if (idx_q == last_q) begin
          fdone_d = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 6'd1;
          state_d = ISSUE;
        end
      end
      default: state_d = BOOT;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge iCLK) begin
    if (rst) begin
      state_q <= BOOT;
      idx_q   <= '0;
      last_q  <= '0;
      sh1_q   <= '0;
      sh2_q   <= '0;
      pend_q  <= 1'b0;
      gap_q   <= '0;
      byte_q  <= '0;
      rs_q    <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      sh1_q   <= sh1_d;
      sh2_q   <= sh2_d;
      pend_q  <= pend_d;
      gap_q   <= gap_d;
      byte_q  <= byte_d;
      rs_q    <= rs_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      fdone_q <= fdone_d;
    end
  end

  assign oByte      = byte_q;
  assign oRS        = rs_q;
  assign oStart     = start_q;
  assign oBusy      = busy_q;
  assign oFrameDone = fdone_q;

endmodule

// File: tb/tb_lcd_refresh_scheduler.sv
// Scoreboard bench for lcd_refresh_scheduler: expected writes queued by stimulus, popped by a write monitor.
module tb_lcd_refresh_scheduler;
  localparam int DLY = 4;
`ifdef LCD_LINE_SKIP_EN
  localparam int UPD1_LAST  = 20;
  localparam int UPD2_FIRST = 21;
`else
  localparam int UPD1_LAST  = 37;
  localparam int UPD2_FIRST = 4;
`endif

  logic         iCLK = 1'b0;
  logic         rst = 1'b1;
  logic [143:0] iLine1, iLine2;
  logic         iRefresh = 1'b0;
  logic [7:0]   oByte;
  logic         oRS, oStart, oBusy, oFrameDone;
  logic         iDone;
  logic         model_done = 1'b1, man_done = 1'b1, manual = 1'b0;
  logic         mon_prev = 1'b0, wm_prev = 1'b0;
  int           wm_cnt = 0;

  logic [8:0]   l1 [16];
  logic [8:0]   l2 [16];
  logic [8:0]   expq [$];
  int           n_vec = 0, n_err = 0, wr_cnt = 0;

  assign iDone = manual ? man_done : model_done;

  always #5 iCLK = ~iCLK;

  lcd_refresh_scheduler #(.DLY_CYCLES(DLY)) dut (
    .iCLK(iCLK), .rst(rst), .iLine1(iLine1), .iLine2(iLine2), .iRefresh(iRefresh),
    .oByte(oByte), .oRS(oRS), .oStart(oStart), .iDone(iDone),
    .oBusy(oBusy), .oFrameDone(oFrameDone)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pack();
    for (int i = 0; i < 16; i++) begin
      iLine1[143-9*i -: 9] = l1[i];
      iLine2[143-9*i -: 9] = l2[i];
    end
  endtask

  function automatic logic [8:0] exp_entry(input int i);
    case (i)
      0: return 9'h038;
      1: return 9'h00C;
      2: return 9'h001;
      3: return 9'h006;
      4: return 9'h080;
      21: return 9'h0C0;
      default: return (i <= 20) ? l1[i-5] : l2[i-22];
    endcase
  endfunction

  task automatic push_frame(input int first, input int last);
    for (int i = first; i <= last; i++) expq.push_back(exp_entry(i));
  endtask

  task automatic wait_fd(input string name, input int budget);
    int n = 0;
    while (!oFrameDone && n < budget) begin
      @(negedge iCLK);
      n++;
    end
    check(name, 32'(oFrameDone), 32'd1);
  endtask

  task automatic wait_start(input string name, input logic lvl, input int budget);
    int n = 0;
    while (oStart !== lvl && n < budget) begin
      @(negedge iCLK);
      n++;
    end
    check(name, 32'(oStart), 32'(lvl));
  endtask

  task automatic frame_end(input string name);
    check({name, "_qempty"}, 32'(expq.size()), 32'd0);
    check({name, "_idle"}, 32'(oBusy), 32'd0);
  endtask

  // Writer model: iDone drops 1 cycle after oStart rises, returns 3 cycles later
  initial begin
    forever begin
      @(posedge iCLK);
      #1;
      if (oStart && !wm_prev) wm_cnt = 1;
      else if (wm_cnt > 0) begin
        wm_cnt++;
        if (wm_cnt == 2) model_done = 1'b0;
        if (wm_cnt == 5) begin
          model_done = 1'b1;
          wm_cnt = 0;
        end
      end
      wm_prev = oStart;
    end
  end

  // Monitor: every oStart rising edge is one byte write
  initial begin
    forever begin
      @(negedge iCLK);
      if (oStart && !mon_prev) begin
        wr_cnt++;
        if (expq.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_write: got %0h expected none", {oRS, oByte});
        end else begin
          check("write", 32'({oRS, oByte}), 32'(expq.pop_front()));
        end
      end
      mon_prev = oStart;
    end
  end

  initial begin
    int base;
    int n;
    for (int i = 0; i < 16; i++) begin
      l1[i] = 9'h120;
      l2[i] = 9'h120;
    end
    pack();
    repeat (3) @(negedge iCLK);
    check("rst_byte", 32'(oByte), 32'd0);
    check("rst_rs", 32'(oRS), 32'd0);
    check("rst_start", 32'(oStart), 32'd0);
    check("rst_busy", 32'(oBusy), 32'd0);
    check("rst_fdone", 32'(oFrameDone), 32'd0);

    // Boot frame
    push_frame(0, 37);
    rst = 1'b0;
    @(negedge iCLK);
    check("boot_lat1", 32'(oStart), 32'd0);
    @(negedge iCLK);
    check("boot_lat2", 32'(oStart), 32'd1);
    wait_fd("boot_done", 1500);
    frame_end("boot");

    // Line 2 change
    @(negedge iCLK);
    l2[0] = 9'h141;
    push_frame(UPD2_FIRST, 37);
    pack();
    @(negedge iCLK);
    check("upd2_lat1_start", 32'(oStart), 32'd0);
    check("upd2_lat1_busy", 32'(oBusy), 32'd1);
    @(negedge iCLK);
    check("upd2_lat2_start", 32'(oStart), 32'd1);
    wait_fd("upd2_done", 1500);
    frame_end("upd2");

    // Stale iDone held high: no progress until a low-high pulse
    @(negedge iCLK);
    manual = 1'b1;
    man_done = 1'b1;
    l1[0] = 9'h142;
    push_frame(4, UPD1_LAST);
    pack();
    wait_start("hold_rise", 1'b1, 10);
    repeat (20) @(negedge iCLK);
    check("hold_start", 32'(oStart), 32'd1);
    check("hold_byte", 32'({oRS, oByte}), 32'h080);
    check("hold_wrcnt_q", 32'(expq.size()), 32'(UPD1_LAST - 4));
    man_done = 1'b0;
    @(negedge iCLK);
    man_done = 1'b1;
    wait_start("hold_release", 1'b0, 10);
    manual = 1'b0;
    wait_fd("hold_done", 1500);
    frame_end("hold");

    // Mid-frame change: current frame keeps shadow, next frame follows immediately
    @(negedge iCLK);
    l1[1] = 9'h143;
    push_frame(4, UPD1_LAST);
    pack();
    base = wr_cnt;
    n = 0;
    while (wr_cnt < base + 10 && n < 500) begin
      @(negedge iCLK);
      n++;
    end
    check("mid_reach10", 32'(wr_cnt >= base + 10), 32'd1);
    l1[2] = 9'h144;
    push_frame(4, UPD1_LAST);
    pack();
    wait_fd("mid_done_a", 1500);
    @(negedge iCLK);
    check("mid_restart_busy", 32'(oBusy), 32'd1);
    check("mid_fdone_pulse", 32'(oFrameDone), 32'd0);
    @(negedge iCLK);
    check("mid_restart_start", 32'(oStart), 32'd1);
    wait_fd("mid_done_b", 1500);
    frame_end("mid");

    // Refresh with no data change
    @(negedge iCLK);
    iRefresh = 1'b1;
    push_frame(4, 37);
    @(negedge iCLK);
    iRefresh = 1'b0;
    wait_fd("refr_done", 1500);
    frame_end("refr");

    // Reset during GAP aborts frame, then full boot reruns
    @(negedge iCLK);
    iRefresh = 1'b1;
    push_frame(4, 6);
    @(negedge iCLK);
    iRefresh = 1'b0;
    base = wr_cnt;
    n = 0;
    while (wr_cnt < base + 3 && n < 200) begin
      @(negedge iCLK);
      n++;
    end
    check("abort_reach3", 32'(wr_cnt >= base + 3), 32'd1);
    wait_start("abort_gap", 1'b0, 20);
    rst = 1'b1;
    @(negedge iCLK);
    check("abort_start", 32'(oStart), 32'd0);
    check("abort_busy", 32'(oBusy), 32'd0);
    check("abort_qempty", 32'(expq.size()), 32'd0);
    push_frame(0, 37);
    @(negedge iCLK);
    rst = 1'b0;
    wait_fd("reboot_done", 1500);
    frame_end("reboot");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/lcd_refresh_scheduler.md
# lcd_refresh_scheduler

Sequencer that owns the 16x2 character LCD byte writer and keeps the panel in step with two 16-character line buffers (plaintext entry line, cipher output line). After reset it runs the full controller init sequence, writes both lines, then idles. It issues a new frame whenever either line buffer changes or a refresh is requested. It sits between the Bit_Converter line buffers and LCD_Controller, replacing the one-shot LUT sequencer and its reset-driven redraw.

## Interface
- `DLY_CYCLES`, default 262142: inter-byte gap in clocks after each completed write.
- `iCLK` input 1: system clock (CLOCK_50).
- `rst` input 1: synchronous, active-high reset.
- `iLine1` input 144: line 1 entries; 16 x 9-bit {RS, byte}, entry 0 at [143:135].
- `iLine2` input 144: line 2 entries, same packing.
- `iRefresh` input 1: one-cycle pulse forcing a redraw of both lines.
- `oByte` output 8: byte to the LCD writer (`iDATA`).
- `oRS` output 1: register select to the writer (`iRS`).
- `oStart` output 1: write request to the writer (`iStart`).
- `iDone` input 1: writer completion (`oDone`).
- `oBusy` output 1: high while a frame is in progress.
- `oFrameDone` output 1: one-cycle pulse after the last byte of a frame.

## Operation
- Sequence index 0..37, one 9-bit entry per index:
  - 0..4: 038, 00C, 001, 006, 080 (init plus line-1 address).
  - 5..20: line 1 entries 0..15.
  - 21: 0C0 (line-2 address).
  - 22..37: line 2 entries 0..15.
- Boot frame covers indices 0..37. Update frame covers 4..37.
- Shadow registers `sh1`/`sh2` are loaded from `iLine1`/`iLine2` at frame start. Character bytes always come from the shadows, so input changes mid-frame never tear a frame.
- `refresh_pending` is set by `iRefresh` in any state and cleared at frame start.
- FSM states: BOOT, IDLE, ISSUE, ARM, WAIT, GAP, ADV.
  - BOOT: entered on reset. Next cycle: load shadows, index=0, last=37, go to ISSUE.
  - IDLE: if `iLine1!=sh1`, `iLine2!=sh2` or `refresh_pending`, then load shadows, set the start index, go to ISSUE. `oBusy`=0 only in IDLE.
  - ISSUE: drive `oByte`/`oRS` from the entry at the index, assert `oStart`, go to ARM.
  - ARM: wait for `iDone`=0. This rejects the stale done from the previous byte.
  - WAIT: on `iDone`=1, deassert `oStart`, clear the gap counter, go to GAP.
  - GAP: count DLY_CYCLES clocks, then go to ADV.
  - ADV: if index==last, pulse `oFrameDone` and go to IDLE. Otherwise increment the index and go to ISSUE.
- `oByte`/`oRS` hold their value from ISSUE through ADV.
- A change that occurs during a frame is detected in IDLE by the shadow compare. The next frame starts on the cycle after IDLE is entered.
- If `rst` is asserted mid-frame, the frame is aborted. `oStart` is 0 on the following cycle and a full boot frame is rerun.

## Timing
- Reset values of all outputs: `oByte`=0, `oRS`=0, `oStart`=0, `oBusy`=0, `oFrameDone`=0.
- First `oStart` rises 2 cycles after `rst` is released (BOOT, then ISSUE).
- `oStart` rises the cycle after ISSUE is entered. It falls the cycle after `iDone` is sampled high in WAIT.
- Per byte: 1 (ISSUE) + ARM/WAIT duration + DLY_CYCLES (GAP) + 1 (ADV).
- Frame start from IDLE: the first `oStart` rises 2 cycles after the trigger is visible.
- `oFrameDone` is high for exactly the cycle IDLE is entered.
- Gap counter is 18 bits wide and saturates at DLY_CYCLES-1. DLY_CYCLES=0 is treated as 1.

## Configuration
- `LCD_LINE_SKIP_EN`, defined: at update-frame start, the scheduler records which lines differ from the shadows.
  - Only line 1 dirty: indices 4..20.
  - Only line 2 dirty: indices 21..37.
  - Both dirty, or `refresh_pending`: indices 4..37.
  - Only the dirty line's shadow is reloaded.
- `LCD_LINE_SKIP_EN`, undefined: every update frame covers 4..37 and reloads both shadows. Boot frames are unaffected either way.

## Test plan
Bench uses DLY_CYCLES=4 and a writer model that drops `iDone` 1 cycle after `oStart` rises and raises it 3 cycles later.
- Reset release, lines all 0x120 (space) -> 38 writes: 038, 00C, 001, 006, 080 with RS=0; 16x 0x20 with RS=1; 0C0; 16x 0x20. Then one `oFrameDone` pulse and `oBusy`=0.
- Idle, set line-2 entry 0 to 0x141 -> with macro: 17 writes, 0C0 then 0x41 followed by 15x 0x20. Without macro: 34 writes starting 080.
- Hold `iDone`=1 continuously after ISSUE -> `oStart` stays high and the index does not advance. Pulse `iDone` low then high -> the sequencer advances.
- Change line 1 at byte 10 of a frame -> the current frame emits the old shadow data. The next frame starts 1 cycle after `oFrameDone` and carries the new data.
- `iRefresh` pulse in IDLE with no data change -> 34-write frame in both configurations.
- Assert `rst` during a GAP -> `oStart` and `oBusy` are 0 the next cycle. After release, the full 38-write boot frame is rerun.
